// File: rtl/eth_pkg.sv
// eth_pkg: shared definitions for the 10BASE-T twisted-pair transmit and
// link-pulse logic. Provides the line-driver state enum, the 20 MHz timing
// constants and a small constant-evaluation helper.
package eth_pkg;

  // Line-driver states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NLP  = 2'd1,
    ST_DATA = 2'd2,
    ST_ETD  = 2'd3
  } eth_state_e;

  // 20 MHz timing: 16 ms NLP spacing, 100 ns link pulse, 300 ns TP_IDL
  localparam int unsigned NLP_PERIOD_20M = 320000;
  localparam int unsigned NLP_WIDTH_20M  = 2;
  localparam int unsigned ETD_CYCLES_20M = 6;

  // Larger of two unsigned values, for sizing shared counters
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/eth_nlp_timer.sv
// eth_nlp_timer: free-running idle counter that spaces Normal Link Pulses.
// Counts every clock while clr is low and wraps to zero at its terminal count.
// Ports:
//   clk   - 20 MHz clock
//   rst   - asynchronous active-high reset
//   clr   - hold the count at zero (asserted whenever the line is not idle)
//   tc_c  - combinational terminal-count strobe (count == PERIOD-1)
module eth_nlp_timer
  import eth_pkg::*;
#(
  parameter int unsigned PERIOD = NLP_PERIOD_20M
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tc_c
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] count;

  assign tc_c = (count == CNT_W'(PERIOD - 1));

  // Count idle clocks; clearing at terminal count keeps the value in range
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || tc_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/eth_tp_tx.sv
// eth_tp_tx: 10BASE-T twisted-pair line driver. Accepts the NRZ frame bit
// stream through a valid/ready bit handshake, Manchester-encodes it onto the
// differential pair, appends TP_IDL after each frame and emits Normal Link
// Pulses while idle. Two clocks make one bit time.
// Ports:
//   clk     - 20 MHz clock
//   rst     - asynchronous active-high reset
//   tx_en   - upstream valid, a frame bit is on tx_data
//   tx_data - NRZ bit, held until accepted
//   bit_ack - ready (combinational); bit taken on an edge with tx_en & bit_ack
//   td_p    - line +, registered
//   td_n    - line -, registered
//   busy    - registered, high in DATA or ETD
module eth_tp_tx
  import eth_pkg::*;
#(
  parameter int unsigned NLP_PERIOD = NLP_PERIOD_20M,
  parameter int unsigned NLP_WIDTH  = NLP_WIDTH_20M,
  parameter int unsigned ETD_CYCLES = ETD_CYCLES_20M
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_en,
  input  logic tx_data,
  output logic bit_ack,
  output logic td_p,
  output logic td_n,
  output logic busy
);

  // One down-counter times both the link pulse and TP_IDL
  localparam int unsigned PW_W = $clog2(max_u(ETD_CYCLES, NLP_WIDTH) + 1);

  eth_state_e      state, state_d;
  logic            phase, phase_d;
  logic            bit_q, bit_d;
  logic [PW_W-1:0] cnt, cnt_d;
  logic            td_p_d, td_n_d;
  logic            level_c;
  logic            nlp_clr_c;
  logic            nlp_tc_c;

  assign nlp_clr_c = (state != ST_IDLE);

  eth_nlp_timer #(
    .PERIOD(NLP_PERIOD)
  ) u_nlp_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (nlp_clr_c),
    .tc_c (nlp_tc_c)
  );

  // State register; line outputs are registered from the next-state view
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      phase <= 1'b0;
      bit_q <= 1'b0;
      cnt   <= '0;
      td_p  <= 1'b0;
      td_n  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      phase <= phase_d;
      bit_q <= bit_d;
      cnt   <= cnt_d;
      td_p  <= td_p_d;
      td_n  <= td_n_d;
      busy  <= (state_d == ST_DATA) || (state_d == ST_ETD);
    end
  end

  // Next-state, handshake and line-level logic
  always_comb begin
    state_d = state;
    phase_d = phase;
    bit_d   = bit_q;
    cnt_d   = cnt;
    bit_ack = 1'b0;
    td_p_d  = 1'b0;
    td_n_d  = 1'b0;
    level_c = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // A due link pulse takes priority over a waiting frame
        if (nlp_tc_c) begin
          state_d = ST_NLP;
          cnt_d   = PW_W'(NLP_WIDTH - 1);
        end else begin
          bit_ack = 1'b1;
          if (tx_en) begin
            bit_d   = tx_data;
            phase_d = 1'b0;
            state_d = ST_DATA;
          end
        end
      end
      ST_NLP: begin
        if (cnt == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt - PW_W'(1);
        end
      end
      ST_DATA: begin
        if (!phase) begin
          phase_d = 1'b1;
        end else begin
          // Second half of a bit: take the next bit back-to-back or close the frame
          bit_ack = 1'b1;
          if (tx_en) begin
            bit_d   = tx_data;
            phase_d = 1'b0;
          end else begin
            state_d = ST_ETD;
            cnt_d   = PW_W'(ETD_CYCLES - 1);
          end
        end
      end
      ST_ETD: begin
        if (cnt == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt - PW_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Manchester: first half carries ~b, second half carries b
    level_c = phase_d ? bit_d : ~bit_d;

    unique case (state_d)
      ST_NLP, ST_ETD: begin
        td_p_d = 1'b1;
      end
      ST_DATA: begin
        td_p_d = level_c;
        td_n_d = ~level_c;
      end
      default: begin
        td_p_d = 1'b0;
        td_n_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_eth_tp_tx.sv
// tb_eth_tp_tx: self-checking bench for eth_tp_tx. A queue-based line model
// predicts the pair levels, busy and bit_ack every clock; directed steps pin
// the key timings with literal expectations.
module tb_eth_tp_tx;

  localparam int unsigned P  = 100;
  localparam int unsigned NW = 2;
  localparam int unsigned EC = 6;

  // Line symbol codes used by the model
  localparam int unsigned C_IDLE = 0;
  localparam int unsigned C_NLP  = 1;
  localparam int unsigned C_HI   = 2;
  localparam int unsigned C_LO   = 3;
  localparam int unsigned C_ETD  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b0;
  logic tx_data = 1'b0;
  logic bit_ack, td_p, td_n, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: current line symbol, queued future symbols, frame-open flag, idle age
  int unsigned cur = C_IDLE;
  int unsigned mq[$];
  bit          frame = 1'b0;
  int unsigned idle_cnt = 0;

  // Upstream source and observation helpers
  bit   src[$];
  bit   fire = 1'b0;
  int   n_acc = 0;
  bit   rec = 1'b0;
  logic rec_p[$];
  int   rec_busy = 0;
  logic exp_seq [15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                         1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  eth_tp_tx #(
    .NLP_PERIOD(P),
    .NLP_WIDTH (NW),
    .ETD_CYCLES(EC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tx_en  (tx_en),
    .tx_data(tx_data),
    .bit_ack(bit_ack),
    .td_p   (td_p),
    .td_n   (td_n),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic model_ack();
    return ((cur == C_IDLE) && (idle_cnt != P - 1)) || (frame && (mq.size() == 0));
  endfunction

  // Advance the model across one clock edge given the sampled inputs
  task automatic model_step(input logic en, input logic d);
    int unsigned nxt;
    if (model_ack() && en) begin
      mq.push_back(d ? C_LO : C_HI);
      mq.push_back(d ? C_HI : C_LO);
      frame = 1'b1;
    end else if (frame && (mq.size() == 0)) begin
      frame = 1'b0;
      repeat (EC) mq.push_back(C_ETD);
    end else if ((cur == C_IDLE) && (idle_cnt == P - 1)) begin
      repeat (NW) mq.push_back(C_NLP);
    end
    nxt = (mq.size() != 0) ? mq.pop_front() : C_IDLE;
    if (nxt == C_IDLE) idle_cnt = (cur == C_IDLE) ? idle_cnt + 1 : 0;
    else idle_cnt = 0;
    cur = nxt;
  endtask

  task automatic model_reset();
    cur = C_IDLE;
    mq.delete();
    frame = 1'b0;
    idle_cnt = 0;
  endtask

  task automatic drive();
    tx_en   = (src.size() != 0);
    tx_data = (src.size() != 0) ? src[0] : 1'b0;
  endtask

  // One clock: check outputs at negedge, step model at posedge, then redrive
  task automatic cycle();
    logic a;
    @(negedge clk);
    chk("td_p", td_p, (cur == C_NLP) || (cur == C_HI) || (cur == C_ETD));
    chk("td_n", td_n, cur == C_LO);
    chk("busy", busy, (cur == C_HI) || (cur == C_LO) || (cur == C_ETD));
    chk("pair_exclusive", td_p & td_n, 1'b0);
    a = model_ack();
    chk("bit_ack", bit_ack, a);
    if (rec) begin
      rec_p.push_back(td_p);
      rec_busy += int'(busy);
    end
    fire = a && tx_en;
    @(posedge clk);
    model_step(tx_en, tx_data);
    #1;
    if (fire) begin
      void'(src.pop_front());
      n_acc++;
    end
    drive();
  endtask

  task automatic load_random(input int len);
    for (int i = 0; i < len; i++) src.push_back(1'($urandom_range(1, 0)));
    drive();
  endtask

  task automatic run_frame_out(input string tag);
    int g = 0;
    while ((src.size() != 0) && (g < 200)) begin
      cycle();
      g++;
    end
    chk_int({tag, "_drained"}, src.size(), 0);
  endtask

  int n;

  initial begin
    // Reset state
    #12;
    chk("rst_td_p", td_p, 1'b0);
    chk("rst_td_n", td_n, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive();

    // Idle link pulses: first at clock 100, width 2, repeating every 102
    rec = 1'b1;
    repeat (210) cycle();
    rec = 1'b0;
    chk("nlp_pre",    rec_p[99],  1'b0);
    chk("nlp1_a",     rec_p[100], 1'b1);
    chk("nlp1_b",     rec_p[101], 1'b1);
    chk("nlp1_end",   rec_p[102], 1'b0);
    chk("nlp2_pre",   rec_p[201], 1'b0);
    chk("nlp2_a",     rec_p[202], 1'b1);
    chk("nlp2_b",     rec_p[203], 1'b1);
    chk("nlp2_end",   rec_p[204], 1'b0);

    // Frame 1,0,1,1: fixed line sequence then TP_IDL
    src = '{1'b1, 1'b0, 1'b1, 1'b1};
    drive();
    cycle();
    chk("frame_first_accept", fire, 1'b1);
    rec_p.delete();
    rec_busy = 0;
    rec = 1'b1;
    repeat (15) cycle();
    rec = 1'b0;
    for (int i = 0; i < 15; i++) chk($sformatf("seq_%0d", i), rec_p[i], exp_seq[i]);
    chk_int("frame_busy_clocks", rec_busy, 14);

    // tx_en rising exactly at the NLP terminal count
    n = 0;
    while (!((cur == C_IDLE) && (idle_cnt == P - 1)) && (n < 300)) begin
      cycle();
      n++;
    end
    chk_int("tc_reached", idle_cnt, P - 1);
    load_random(8);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!fire && (n < 10));
    chk_int("tc_accept_delay", n, 4);
    run_frame_out("tc_frame");
    repeat (20) cycle();

    // tx_en reasserted in the first ETD clock: held off until IDLE
    load_random(3);
    run_frame_out("etd_frame_a");
    cycle();
    cycle();
    load_random(5);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!fire && (n < 20));
    chk_int("etd_holdoff", n, 7);
    run_frame_out("etd_frame_b");
    repeat (12) cycle();

    // Single-bit frame
    load_random(1);
    run_frame_out("single_bit");
    repeat (12) cycle();

    // Randomized frames with random gaps, some long enough to cross an NLP
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(150, 0)) cycle();
      load_random(int'($urandom_range(20, 1)));
      run_frame_out("rand_frame");
    end
    repeat (10) cycle();

    // Async reset in phase 0 of bit 5
    load_random(8);
    n_acc = 0;
    n = 0;
    while ((n_acc < 5) && (n < 50)) begin
      cycle();
      n++;
    end
    chk_int("bit5_reached", n_acc, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_td_p", td_p, 1'b0);
    chk("async_td_n", td_n, 1'b0);
    chk("async_busy", busy, 1'b0);
    src.delete();
    drive();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rec_p.delete();
    rec = 1'b1;
    repeat (105) cycle();
    rec = 1'b0;
    chk("post_rst_pre",  rec_p[99],  1'b0);
    chk("post_rst_nlp",  rec_p[100], 1'b1);
    chk("post_rst_nlp2", rec_p[101], 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
